wb_trace_buffer: RTL and testbench
==================================

# wb_trace_buffer

Register-writeback trace capture that observes the regfile write port driven by the processor (`ctrl_writeEnable`, `ctrl_writeReg`, `data_writeReg`). It timestamps each qualifying write and buffers it in a FIFO. A bench or debug host drains the FIFO through a valid/ready handshake. The block sits beside `regfile` on the `regfile_clock` domain and is purely an observer: it never drives the regfile.

## Interface
- `DEPTH`, 16, FIFO entries; power of two, at least 2.
- `STAMP_W`, 16, cycle-stamp width.
- `DROP_W`, 8, saturating drop-counter width.
- `clock`  in  1  sole clock; connect to `regfile_clock`.
- `reset`  in  1  asynchronous, active-low reset.
- `ctrl_writeEnable`  in  1  observed regfile write enable.
- `ctrl_writeReg`  in  5  observed destination register.
- `data_writeReg`  in  32  observed write data.
- `trace_enable`  in  1  capture gate.
- `filter_zero`  in  1  when 1, writes to `$r0` are ignored.
- `clear`  in  1  synchronous flush.
- `out_valid`  out  1  head entry available.
- `out_ready`  in  1  consumer accepts the head entry.
- `out_reg`  out  5  head register number.
- `out_data`  out  32  head data.
- `out_stamp`  out  STAMP_W  head cycle stamp.
- `count`  out  $clog2(DEPTH)+1  current occupancy.
- `drop_count`  out  DROP_W  writes lost while full; saturates.
- `overflow`  out  1  sticky; set on the first drop.

## Operation
- **Stamp counter.** Free-running, +1 every clock, wraps from 2^STAMP_W−1 to 0. `clear` does not affect it.
- **Push condition.** `push = trace_enable & ctrl_writeEnable & ~(filter_zero & ctrl_writeReg==0)`.
- **Entry contents.** Each entry is {stamp value at the capture edge, `ctrl_writeReg`, `data_writeReg`}.
- **Pop condition.** `pop = out_valid & out_ready`.
- **Output view.** `out_valid = (count != 0)`. `out_*` always show the head entry. Their values while `out_valid=0` are don't-care but must be stable, with no X.
- **Full without pop.** The push is dropped. `drop_count` increments, saturating at 2^DROP_W−1, and `overflow` sets.
- **Full with simultaneous pop.** Both the push and the pop occur. `count` stays at DEPTH and nothing is dropped.
- **Empty with simultaneous push.** The entry is written. `out_valid` rises next cycle. There is no bypass.
- **Clear.** Sets `count`, both pointers, `drop_count` and `overflow` to 0. It has priority over any push or pop in the same cycle, and that cycle's write is discarded.
- **Pointers.** Read and write pointers wrap modulo DEPTH. Occupancy is tracked with an explicit counter.

## Timing
- **Reset values.** While `reset` is low, asynchronously: `count=0`, pointers=0, stamp=0, `drop_count=0`, `overflow=0`, `out_valid=0`, `out_reg/out_data/out_stamp=0`.
- **Reset mid-operation.** All buffered entries are lost. There is no partial state.
- **Capture latency.** A write sampled at edge N appears at the head at edge N+1 if the FIFO was empty.
- **Pop.** Takes effect at the edge where `out_valid & out_ready` is high. The next entry is presented after that edge.
- **Outputs.** `out_*` and all status outputs come from registers or the storage array. There is no combinational path from `out_ready` to `out_valid` or `out_*`.
- **Throughput.** One push and one pop per cycle sustained.
- **Status update.** `count`, `drop_count` and `overflow` update at the same edge as the push or pop they reflect.

## Structure
- **Shared package `wb_trace_pkg`.**
  - Constants: `REG_W=5`, `DATA_W=32`, default `STAMP_W`, `DROP_W`.
  - Entry layout/typedef `wb_trace_entry_t` = {stamp, reg, data}.
- **One sub-module: `wb_trace_fifo`.**
  - Generic synchronous FIFO with push/pop, clear, and full/empty/count outputs.
  - Parameterised by width and depth.
- **Top level** holds the stamp counter, push filter, and drop/overflow logic.

## Test plan
- **Reset.** Hold `reset` low mid-stream with 5 entries queued, then release → `out_valid=0`, `count=0`, stamp restarts at 0, `drop_count=0`.
- **Capture latency and filter.** `filter_zero=1`, `trace_enable=1`; write $r0=0x1234 at stamp 10 and $r7=0xDEADBEEF at stamp 11 → exactly one entry {stamp=11, reg=7, data=0xDEADBEEF}, `out_valid` high from stamp 12.
- **Overflow.** `out_ready=0`; write 20 consecutive register writes with DEPTH=16 → `count=16`, `drop_count=4`, `overflow=1`. Draining returns the first 16 writes in order.
- **Full with simultaneous push/pop.** FIFO full, `out_ready=1` and a write in the same cycle → `count` stays 16, `drop_count` unchanged, new entry appears as the 16th.
- **Clear priority.** `clear=1` with push and pop asserted in the same cycle and 3 entries queued → next cycle `count=0`, `out_valid=0`, `overflow=0`; stamp continues uninterrupted.
- **Stamp wrap.** Run 65 535 idle cycles, then write → captured stamp 0xFFFF; a write on the next cycle carries stamp 0x0000.

Source files
------------

// File: rtl/wb_trace_pkg.sv
// Shared constants and trace-entry layout for the regfile writeback trace buffer.
package wb_trace_pkg;
   localparam int REG_W       = 5;
   localparam int DATA_W      = 32;
   localparam int DEF_STAMP_W = 16;
   localparam int DEF_DROP_W  = 8;

   typedef struct packed {
      logic [DEF_STAMP_W-1:0] stamp;
      logic [REG_W-1:0]       rd;
      logic [DATA_W-1:0]      data;
   } wb_trace_entry_t;

   function automatic int entry_width(input int stamp_w);
      return stamp_w + REG_W + DATA_W;
   endfunction
endpackage

// File: rtl/wb_trace_fifo.sv
// Generic synchronous FIFO: explicit occupancy counter, push accepted when full only alongside a pop.
// Storage is reset so the head is never X, even before the first push.
module wb_trace_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   clear_i,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       wdata_i,
   input  logic                   pop_i,
   output logic [WIDTH-1:0]       rdata_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i & (~full_o | pop_i);
   assign do_pop  = pop_i & ~empty_o;
   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (do_push && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
      end
   end
endmodule

// File: rtl/wb_trace_buffer.sv
// Observes the regfile write port, stamps qualifying writes and queues them for a valid/ready consumer.
// Writes arriving while full (and not popping) are dropped and counted; the observer never stalls the core.
module wb_trace_buffer
   import wb_trace_pkg::*;
#(
   parameter int DEPTH   = 16,
   parameter int STAMP_W = DEF_STAMP_W,
   parameter int DROP_W  = DEF_DROP_W
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   ctrl_writeEnable,
   input  logic [REG_W-1:0]       ctrl_writeReg,
   input  logic [DATA_W-1:0]      data_writeReg,
   input  logic                   trace_enable,
   input  logic                   filter_zero,
   input  logic                   clear,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [REG_W-1:0]       out_reg,
   output logic [DATA_W-1:0]      out_data,
   output logic [STAMP_W-1:0]     out_stamp,
   output logic [$clog2(DEPTH):0] count,
   output logic [DROP_W-1:0]      drop_count,
   output logic                   overflow
);
   localparam int ENTRY_W = entry_width(STAMP_W);

   logic [STAMP_W-1:0] stamp_q, stamp_d;
   logic [DROP_W-1:0]  drop_q, drop_d;
   logic               overflow_q, overflow_d;
   logic               push, pop, full, empty, drop;
   logic [ENTRY_W-1:0] wr_entry, rd_entry;

   assign push      = trace_enable & ctrl_writeEnable & ~(filter_zero & (ctrl_writeReg == '0));
   assign out_valid = ~empty;
   assign pop       = out_valid & out_ready;
   assign drop      = push & full & ~pop & ~clear;
   assign wr_entry  = {stamp_q, ctrl_writeReg, data_writeReg};
   assign {out_stamp, out_reg, out_data} = rd_entry;
   assign drop_count = drop_q;
   assign overflow   = overflow_q;

   // The stamp free-runs through clear so trace time stays continuous across flushes.
   always_comb begin
      stamp_d    = stamp_q + 1'b1;
      drop_d     = drop_q;
      overflow_d = overflow_q;
      if (drop) begin
         overflow_d = 1'b1;
         if (drop_q != '1) drop_d = drop_q + 1'b1;
      end
      if (clear) begin
         drop_d     = '0;
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stamp_q    <= '0;
         drop_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         stamp_q    <= stamp_d;
         drop_q     <= drop_d;
         overflow_q <= overflow_d;
      end
   end

   wb_trace_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clock),
      .rst_ni  (reset),
      .clear_i (clear),
      .push_i  (push),
      .wdata_i (wr_entry),
      .pop_i   (pop),
      .rdata_o (rd_entry),
      .full_o  (full),
      .empty_o (empty),
      .count_o (count)
   );
endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer; expected entries go to a scoreboard queue, a forked monitor checks pops.
module tb_wb_trace_buffer;
   import wb_trace_pkg::*;

   logic        clock;
   logic        reset;
   logic        ctrl_writeEnable;
   logic [4:0]  ctrl_writeReg;
   logic [31:0] data_writeReg;
   logic        trace_enable;
   logic        filter_zero;
   logic        clear;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_reg;
   logic [31:0] out_data;
   logic [15:0] out_stamp;
   logic [4:0]  count;
   logic [7:0]  drop_count;
   logic        overflow;

   wb_trace_buffer #(.DEPTH(16), .STAMP_W(16), .DROP_W(8)) dut (
      .clock            (clock),
      .reset            (reset),
      .ctrl_writeEnable (ctrl_writeEnable),
      .ctrl_writeReg    (ctrl_writeReg),
      .data_writeReg    (data_writeReg),
      .trace_enable     (trace_enable),
      .filter_zero      (filter_zero),
      .clear            (clear),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_reg          (out_reg),
      .out_data         (out_data),
      .out_stamp        (out_stamp),
      .count            (count),
      .drop_count       (drop_count),
      .overflow         (overflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference cycle counter: the stamp a write captures is this value during its cycle.
   logic [15:0] tb_stamp;
   always @(posedge clock or negedge reset)
      if (!reset) tb_stamp <= 16'd0;
      else        tb_stamp <= tb_stamp + 16'd1;

   int checks = 0;
   int errors = 0;
   wb_trace_entry_t sb[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [4:0] r, input logic [31:0] d, input bit exp, input logic [15:0] st);
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg    = r;
      data_writeReg    = d;
      if (exp) sb.push_back({st, r, d});
      tick();
      ctrl_writeEnable = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      out_ready = 1'b1;
      while (count != 0 && n < 40) begin
         tick();
         n++;
      end
      out_ready = 1'b0;
      chk("drain_count", count, 0);
   endtask

   task automatic monitor();
      wb_trace_entry_t g, e;
      forever begin
         @(negedge clock);
         if (reset && out_valid && out_ready && !clear) begin
            g = {out_stamp, out_reg, out_data};
            chk("sb_nonempty_on_pop", sb.size() > 0, 1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk("entry", g, e);
            end
         end
      end
   endtask

   initial begin
      logic [15:0] s0;
      reset            = 1'b0;
      ctrl_writeEnable = 1'b0;
      ctrl_writeReg    = '0;
      data_writeReg    = '0;
      trace_enable     = 1'b0;
      filter_zero      = 1'b0;
      clear            = 1'b0;
      out_ready        = 1'b0;
      fork
         monitor();
      join_none

      // Reset values
      repeat (2) @(posedge clock);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_count", count, 0);
      chk("rst_drop", drop_count, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_head", {out_stamp, out_reg, out_data}, 0);
      reset = 1'b1;

      // Capture latency and $r0 filter
      trace_enable = 1'b1;
      filter_zero  = 1'b1;
      while (tb_stamp != 16'd10) tick();
      wr(5'd0, 32'h1234, 1'b0, 16'd10);
      chk("filter_r0_count", count, 0);
      wr(5'd7, 32'hDEADBEEF, 1'b1, 16'd11);
      chk("capture_valid", out_valid, 1);
      chk("capture_count", count, 1);
      chk("capture_head", {out_stamp, out_reg, out_data}, {16'd11, 5'd7, 32'hDEADBEEF});
      drain();

      // Overflow: 20 writes into 16 entries, no consumer
      for (int i = 0; i < 20; i++) wr(5'(i + 1), 32'h100 + 32'(i), i < 16, tb_stamp);
      chk("ovf_count", count, 16);
      chk("ovf_drop", drop_count, 4);
      chk("ovf_flag", overflow, 1);

      // Full with simultaneous push and pop
      out_ready = 1'b1;
      wr(5'd21, 32'hAAAA, 1'b1, tb_stamp);
      out_ready = 1'b0;
      chk("fullpp_count", count, 16);
      chk("fullpp_drop", drop_count, 4);
      drain();

      // Drop counter saturation
      for (int i = 0; i < 276; i++) wr(5'(i % 31 + 1), 32'h2000 + 32'(i), i < 16, tb_stamp);
      chk("sat_drop", drop_count, 255);
      chk("sat_overflow", overflow, 1);
      drain();

      // Clear wins over push and pop in the same cycle
      for (int i = 0; i < 3; i++) wr(5'(i + 1), 32'h300 + 32'(i), 1'b1, tb_stamp);
      chk("pre_clear_count", count, 3);
      s0 = tb_stamp;
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg    = 5'd9;
      data_writeReg    = 32'h99;
      out_ready        = 1'b1;
      clear            = 1'b1;
      tick();
      clear            = 1'b0;
      ctrl_writeEnable = 1'b0;
      out_ready        = 1'b0;
      sb.delete();
      chk("clear_count", count, 0);
      chk("clear_valid", out_valid, 0);
      chk("clear_overflow", overflow, 0);
      chk("clear_drop", drop_count, 0);
      wr(5'd10, 32'hA0, 1'b1, s0 + 16'd1);
      drain();

      // Reset mid-stream with 5 entries queued
      for (int i = 0; i < 5; i++) wr(5'(i + 1), 32'h500 + 32'(i), 1'b1, tb_stamp);
      chk("pre_reset_count", count, 5);
      reset = 1'b0;
      #1;
      chk("async_rst_count", count, 0);
      chk("async_rst_valid", out_valid, 0);
      tick();
      reset = 1'b1;
      sb.delete();
      chk("post_rst_drop", drop_count, 0);
      chk("post_rst_head", {out_stamp, out_reg, out_data}, 0);
      wr(5'd3, 32'h33, 1'b1, 16'd0);
      drain();

      // Stamp wrap
      while (tb_stamp != 16'hFFFF) tick();
      wr(5'd5, 32'h55, 1'b1, 16'hFFFF);
      wr(5'd6, 32'h66, 1'b1, 16'h0000);
      drain();

      tick();
      chk("sb_empty_at_end", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
